// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         BYTES_PER_WORD    = 4;

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, LSB-first shift register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_e;

  rx_state_e   state;
  logic [1:0]  sync;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rx_s;

  assign rx_s = sync[1];

  // The start phase waits half a bit so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_BITS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a framed program over UART and writes it into imem, holding the core in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_WIDTH   = 5,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [31:0]           imem_din,
  output logic [31:0]           imem_addr,
  output logic                  imem_web,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int         NW        = ADDR_WIDTH + 1;
  localparam logic [8:0] MAX_WORDS = 9'(1 << ADDR_WIDTH);

  loader_state_e state;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          frame_err;
  logic [NW-1:0] n_words;
  logic [NW-1:0] word_idx;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_buf;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // Frame FSM; all imem and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      imem_web     <= 1'b1;
      imem_addr    <= '0;
      imem_din     <= '0;
      core_rst     <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            state     <= LEN;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
          end
        end
        LEN: begin
          if (frame_err) begin
            state    <= ERROR;
            load_err <= 1'b1;
          end else if (rx_valid) begin
            if (rx_byte == 8'd0 || {1'b0, rx_byte} > MAX_WORDS) begin
              state    <= ERROR;
              load_err <= 1'b1;
            end else begin
              state        <= DATA;
              n_words      <= NW'(rx_byte);
              word_idx     <= '0;
              byte_cnt     <= '0;
              words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
              csum         <= '0;
`endif
            end
          end
        end
        DATA: begin
          if (frame_err) begin
            state    <= ERROR;
            load_err <= 1'b1;
          end else if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_byte;
`endif
            if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
              byte_cnt  <= '0;
              imem_din  <= {rx_byte, word_buf};
              imem_addr <= {{(30 - ADDR_WIDTH){1'b0}}, word_idx[ADDR_WIDTH-1:0], 2'b00};
              imem_web  <= 1'b0;
              state     <= WRITE;
            end else begin
              word_buf[8*byte_cnt +: 8] <= rx_byte;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          imem_web     <= 1'b1;
          word_idx     <= word_idx + 1'b1;
          words_loaded <= words_loaded + 1'b1;
          if (word_idx + NW'(1) == n_words) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state     <= DONE;
            core_rst  <= 1'b0;
            load_done <= 1'b1;
`endif
          end else begin
            state <= DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (frame_err || (rx_valid && rx_byte != csum)) begin
            state    <= ERROR;
            load_err <= 1'b1;
          end else if (rx_valid) begin
            state     <= DONE;
            core_rst  <= 1'b0;
            load_done <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: expected SRAM writes are queued by the stimulus
// and checked by an independent monitor on every imem_web low cycle.
module tb_imem_uart_loader;

  localparam int CPB = 8;
  localparam int AW  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] imem_din;
  logic [31:0] imem_addr;
  logic        imem_web;
  logic        core_rst;
  logic        load_done;
  logic        load_err;
  logic [AW:0] words_loaded;

  int          vectors     = 0;
  int          miscompares = 0;
  int          low_run     = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  bench_csum;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .imem_din     (imem_din),
    .imem_addr    (imem_addr),
    .imem_web     (imem_web),
    .core_rst     (core_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Each write is popped against the queue; a write with nothing queued is an error.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && imem_web === 1'b0) begin
      low_run++;
      if (low_run > 1) check_output("web_pulse_width", 32'(low_run), 32'd1);
      if (exp_q.size() == 0) begin
        check_output("unexpected_write_addr", imem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_output("write_addr", imem_addr, e[63:32]);
        check_output("write_data", imem_din, e[31:0]);
      end
    end else begin
      low_run = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx);
    exp_q.push_back({32'(idx * 4), w});
    for (int k = 0; k < 4; k++) begin
      bench_csum = bench_csum ^ w[8*k +: 8];
      send_byte(w[8*k +: 8], 1'b1);
    end
  endtask

  task automatic send_trailer(input logic corrupt);
`ifdef LOADER_CHECKSUM_EN
    send_byte(corrupt ? (bench_csum ^ 8'h01) : bench_csum, 1'b1);
`else
    if (corrupt) $display("[TB] checksum corruption requested without checksum build");
`endif
  endtask

  task automatic send_two_word_frame();
    bench_csum = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 1);
    send_trailer(1'b0);
    repeat (16) @(negedge clk);
  endtask

  task automatic check_done(input string tag, input logic [31:0] n);
    check_output({tag, "_load_done"}, 32'(load_done), 32'd1);
    check_output({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    check_output({tag, "_load_err"}, 32'(load_err), 32'd0);
    check_output({tag, "_words_loaded"}, 32'(words_loaded), n);
    check_output({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_error(input string tag);
    check_output({tag, "_load_err"}, 32'(load_err), 32'd1);
    check_output({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check_output({tag, "_load_done"}, 32'(load_done), 32'd0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_output("reset_web", 32'(imem_web), 32'd1);
    check_output("reset_core_rst", 32'(core_rst), 32'd1);
    check_output("reset_load_done", 32'(load_done), 32'd0);
    check_output("reset_load_err", 32'(load_err), 32'd0);
    check_output("reset_words", 32'(words_loaded), 32'd0);
    check_output("reset_addr", imem_addr, 32'd0);
    rst = 1'b0;

    // Noise before any sync byte is ignored.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (16) @(negedge clk);
    check_output("noise_core_rst", 32'(core_rst), 32'd1);
    check_output("noise_load_done", 32'(load_done), 32'd0);

    send_two_word_frame();
    check_done("frame1", 32'd2);
    check_output("frame1_last_addr", imem_addr, 32'h0000_0004);

    // Noise in DONE is ignored, then a reload runs.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (16) @(negedge clk);
    check_output("done_noise_load_done", 32'(load_done), 32'd1);
    send_two_word_frame();
    check_done("reload", 32'd2);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (16) @(negedge clk);
    check_error("len_zero");

    send_byte(8'hA5, 1'b1);
    send_byte(8'h21, 1'b1);
    repeat (16) @(negedge clk);
    check_error("len_33");

    // Bad stop bit on the third data byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (16 * CPB) @(negedge clk);
    check_error("stop_bit");
    check_output("stop_bit_words", 32'(words_loaded), 32'd0);
    send_two_word_frame();
    check_done("recover", 32'd2);

    // Reset mid-frame after the first word has been written.
    bench_csum = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'h0000_0013, 0);
    repeat (16) @(negedge clk);
    check_output("midload_words", 32'(words_loaded), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("midrst_web", 32'(imem_web), 32'd1);
    check_output("midrst_addr", imem_addr, 32'd0);
    check_output("midrst_din", imem_din, 32'd0);
    check_output("midrst_core_rst", 32'(core_rst), 32'd1);
    check_output("midrst_load_done", 32'(load_done), 32'd0);
    check_output("midrst_load_err", 32'(load_err), 32'd0);
    check_output("midrst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    bench_csum = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(32'hDEAD_BEEF, 0);
    send_trailer(1'b0);
    repeat (16) @(negedge clk);
    check_done("after_rst", 32'd1);
    check_output("after_rst_addr", imem_addr, 32'd0);
    check_output("after_rst_din", imem_din, 32'hDEAD_BEEF);

`ifdef LOADER_CHECKSUM_EN
    // Both words land before the wrong checksum byte is judged.
    bench_csum = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 1);
    check_output("csum_value", 32'(bench_csum), 32'h0000_0090);
    send_trailer(1'b1);
    repeat (16) @(negedge clk);
    check_error("bad_csum");
    check_output("bad_csum_words", 32'(words_loaded), 32'd2);
    check_output("bad_csum_queue", 32'(exp_q.size()), 32'd0);
`endif

    check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
